// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and a
// helper that sizes the accumulator so a full frame can never wrap.
package product_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_t;

    // Smallest ACC_WIDTH that holds FRAME_LEN maximal products without a carry out.
    function automatic int min_acc_width(input int product_width, input int frame_len);
        return product_width + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Purely combinational WIDTH-bit unsigned adder exposing the carry out of the
// top bit; shared with the MAC blocks that reuse the accumulation datapath.
module acc_adder_carry #(
    parameter int WIDTH = 72
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator behind the multiplier: sums FRAME_LEN products (or fewer on
// flush) and holds the frame sum on a valid/ready output until it is taken.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PRODUCT_WIDTH = 64,
    parameter int ACC_WIDTH     = 72,
    parameter int FRAME_LEN     = 8,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRODUCT_WIDTH-1:0] in_product,
    input  logic                     in_flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0]     out_count,
    output logic                     out_overflow
);

    localparam logic [CNT_WIDTH-1:0] FRAME_LEN_CNT = CNT_WIDTH'(FRAME_LEN);

    acc_state_t state_reg;
    acc_state_t state_next;

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_post;
    logic [ACC_WIDTH-1:0] add_sum;
    logic [ACC_WIDTH-1:0] product_ext;
    logic                 add_carry;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_post;
    logic                 ovf_reg;
    logic                 ovf_post;
    logic                 accept;
    logic                 frame_end;

    logic [ACC_WIDTH-1:0] out_sum_reg;
    logic [CNT_WIDTH-1:0] out_count_reg;
    logic                 out_overflow_reg;

    assign product_ext = ACC_WIDTH'(in_product);

    acc_adder_carry #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .a     (acc_reg),
        .b     (product_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Post-update values: what the frame looks like once this cycle's beat lands.
    assign cnt_inc  = cnt_reg + 1'b1;
    assign acc_post = accept ? add_sum : acc_reg;
    assign cnt_post = accept ? cnt_inc : cnt_reg;
    assign ovf_post = ovf_reg | (accept & add_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                // Flush is honoured even without a beat, giving an empty frame.
                if ((in_valid && (cnt_inc == FRAME_LEN_CNT)) || in_flush) begin
                    frame_end  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg          <= '0;
            cnt_reg          <= '0;
            ovf_reg          <= 1'b0;
            out_sum_reg      <= '0;
            out_count_reg    <= '0;
            out_overflow_reg <= 1'b0;
        end else if (state_reg == ST_ACCUM) begin
            acc_reg <= acc_post;
            cnt_reg <= cnt_post;
            ovf_reg <= ovf_post;
            if (frame_end) begin
                out_sum_reg      <= acc_post;
                out_count_reg    <= cnt_post;
                out_overflow_reg <= ovf_post;
            end
        end else if (out_ready) begin
            // Result handed off: start the next frame clean; out_* keep their values.
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end
    end

    assign out_sum      = out_sum_reg;
    assign out_count    = out_count_reg;
    assign out_overflow = out_overflow_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed frames plus a randomized run of two
// instances (wide, and a narrow one that wraps) against a frame-level model.
module tb_product_accumulator;

    localparam int A_PW = 64;
    localparam int A_AW = 72;
    localparam int A_FL = 4;
    localparam int B_PW = 8;
    localparam int B_AW = 8;
    localparam int B_FL = 2;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic            a_in_valid, a_in_ready, a_in_flush, a_out_valid, a_out_ready, a_out_overflow;
    logic [A_PW-1:0] a_in_product;
    logic [A_AW-1:0] a_out_sum;
    logic [CW-1:0]   a_out_count;

    logic            b_in_valid, b_in_ready, b_in_flush, b_out_valid, b_out_ready, b_out_overflow;
    logic [B_PW-1:0] b_in_product;
    logic [B_AW-1:0] b_out_sum;
    logic [CW-1:0]   b_out_count;

    product_accumulator #(
        .PRODUCT_WIDTH (A_PW), .ACC_WIDTH (A_AW), .FRAME_LEN (A_FL), .CNT_WIDTH (CW)
    ) dut_a (
        .clk (clk), .rst_n (rst_n),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_product (a_in_product), .in_flush (a_in_flush),
        .out_valid (a_out_valid), .out_ready (a_out_ready), .out_sum (a_out_sum),
        .out_count (a_out_count), .out_overflow (a_out_overflow)
    );

    product_accumulator #(
        .PRODUCT_WIDTH (B_PW), .ACC_WIDTH (B_AW), .FRAME_LEN (B_FL), .CNT_WIDTH (CW)
    ) dut_b (
        .clk (clk), .rst_n (rst_n),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_product (b_in_product), .in_flush (b_in_flush),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .out_sum (b_out_sum),
        .out_count (b_out_count), .out_overflow (b_out_overflow)
    );

    // One beat on instance A; entered and left at a falling edge.
    task automatic a_push(input logic [A_PW-1:0] p, input logic flush);
        a_in_valid   = 1'b1;
        a_in_product = p;
        a_in_flush   = flush;
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL a_push_ready: in_ready=%b want 1 (product %0d)", a_in_ready, p);
        end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_flush = 1'b0;
    endtask

    task automatic b_push(input logic [B_PW-1:0] p);
        b_in_valid   = 1'b1;
        b_in_product = p;
        b_in_flush   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic drain;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if ({a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 1'b0, 72'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_a: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow);
        end
        n_vec++;
        if ({b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_b: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want 1 0 0 0 0",
                     b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        a_out_ready = 1'b1;
        a_push(3, 1'b0); a_push(5, 1'b0); a_push(7, 1'b0); a_push(9, 1'b0);
        n_vec++;
        if ({a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 1'b0, 72'd24, 8'd4, 1'b0}) begin
            n_err++;
            $display("FAIL basic_frame: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b want 1 0 24 4 0",
                     a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_overflow);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({a_out_valid, a_in_ready, a_out_sum, a_out_count} !== {1'b0, 1'b1, 72'd24, 8'd4}) begin
            n_err++;
            $display("FAIL basic_handoff: vld=%b rdy=%b sum=%0d cnt=%0d want 0 1 24 4",
                     a_out_valid, a_in_ready, a_out_sum, a_out_count);
        end
    endtask

    task automatic test_back_to_back;
        a_out_ready = 1'b0;
        a_push(3, 1'b0); a_push(5, 1'b0); a_push(7, 1'b0); a_push(9, 1'b0);
        // Beats and flush offered during HOLD must be ignored.
        a_in_valid   = 1'b1;
        a_in_product = 1000;
        a_in_flush   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 1'b0, 72'd24, 8'd4, 1'b0}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b want 1 0 24 4 0",
                         i, a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_overflow);
            end
            @(posedge clk);
            @(negedge clk);
        end
        a_in_valid  = 1'b0;
        a_in_flush  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_flush;
        a_push(10, 1'b0); a_push(20, 1'b0); a_push(30, 1'b1);
        n_vec++;
        if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 72'd60, 8'd3, 1'b0}) begin
            n_err++;
            $display("FAIL flush_frame: vld=%b sum=%0d cnt=%0d ovf=%b want 1 60 3 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_overflow);
        end
        drain();
    endtask

    task automatic test_async_reset;
        a_push(5, 1'b0); a_push(6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 1'b0, 72'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_push(1, 1'b0); a_push(1, 1'b0); a_push(1, 1'b0); a_push(1, 1'b0);
        n_vec++;
        if ({a_out_valid, a_out_sum, a_out_count} !== {1'b1, 72'd4, 8'd4}) begin
            n_err++;
            $display("FAIL post_reset_frame: vld=%b sum=%0d cnt=%0d want 1 4 4", a_out_valid, a_out_sum, a_out_count);
        end
        drain();
    endtask

    task automatic test_empty_flush;
        a_in_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_flush = 1'b0;
        n_vec++;
        if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, 72'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL empty_flush: vld=%b sum=%0d cnt=%0d ovf=%b want 1 0 0 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_overflow);
        end
        drain();
    endtask

    task automatic test_overflow;
        b_out_ready = 1'b1;
        b_push(200); b_push(100);
        n_vec++;
        if ({b_out_valid, b_out_sum, b_out_count, b_out_overflow} !== {1'b1, 8'd44, 8'd2, 1'b1}) begin
            n_err++;
            $display("FAIL overflow_frame: vld=%b sum=%0d cnt=%0d ovf=%b want 1 44 2 1",
                     b_out_valid, b_out_sum, b_out_count, b_out_overflow);
        end
        drain();
        b_push(1); b_push(2);
        n_vec++;
        if ({b_out_valid, b_out_sum, b_out_count, b_out_overflow} !== {1'b1, 8'd3, 8'd2, 1'b0}) begin
            n_err++;
            $display("FAIL overflow_cleared: vld=%b sum=%0d cnt=%0d ovf=%b want 1 3 2 0",
                     b_out_valid, b_out_sum, b_out_count, b_out_overflow);
        end
        drain();
    endtask

    // Both instances driven at random; the model only tracks which products
    // belong to the open frame and whether a finished frame is awaiting pickup.
    task automatic test_random(input int cycles);
        logic [A_PW-1:0] qa[$];
        logic [B_PW-1:0] qb[$];
        bit              ha = 1'b0, hb = 1'b0;
        logic [127:0]    tsum;
        logic [A_AW-1:0] ea_sum = '0;
        logic [B_AW-1:0] eb_sum = '0;
        logic [CW-1:0]   ea_cnt = '0, eb_cnt = '0;
        logic            ea_ovf = 1'b0, eb_ovf = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            n_vec++;
            if ({a_in_ready, a_out_valid} !== {~ha, ha} ||
                (ha && {a_out_sum, a_out_count, a_out_overflow} !== {ea_sum, ea_cnt, ea_ovf})) begin
                n_err++;
                $display("FAIL rand_a[%0d]: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b",
                         c, a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow,
                         ~ha, ha, ea_sum, ea_cnt, ea_ovf);
            end
            n_vec++;
            if ({b_in_ready, b_out_valid} !== {~hb, hb} ||
                (hb && {b_out_sum, b_out_count, b_out_overflow} !== {eb_sum, eb_cnt, eb_ovf})) begin
                n_err++;
                $display("FAIL rand_b[%0d]: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b",
                         c, b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow,
                         ~hb, hb, eb_sum, eb_cnt, eb_ovf);
            end
            a_in_valid   = ($urandom_range(0, 3) != 0);
            a_in_product = {$urandom, $urandom};
            a_in_flush   = ($urandom_range(0, 7) == 0);
            a_out_ready  = ($urandom_range(0, 2) != 0);
            b_in_valid   = ($urandom_range(0, 3) != 0);
            b_in_product = B_PW'($urandom_range(0, 255));
            b_in_flush   = ($urandom_range(0, 7) == 0);
            b_out_ready  = ($urandom_range(0, 2) != 0);
            if (!ha) begin
                if (a_in_valid) qa.push_back(a_in_product);
                if ((a_in_valid && qa.size() == A_FL) || a_in_flush) begin
                    tsum = '0;
                    foreach (qa[i]) tsum += 128'(qa[i]);
                    ea_sum = tsum[A_AW-1:0];
                    ea_ovf = ((tsum >> A_AW) != 0);
                    ea_cnt = CW'(qa.size());
                    qa.delete();
                    ha = 1'b1;
                end
            end else if (a_out_ready) begin
                ha = 1'b0;
            end
            if (!hb) begin
                if (b_in_valid) qb.push_back(b_in_product);
                if ((b_in_valid && qb.size() == B_FL) || b_in_flush) begin
                    tsum = '0;
                    foreach (qb[i]) tsum += 128'(qb[i]);
                    eb_sum = tsum[B_AW-1:0];
                    eb_ovf = ((tsum >> B_AW) != 0);
                    eb_cnt = CW'(qb.size());
                    qb.delete();
                    hb = 1'b1;
                end
            end else if (b_out_ready) begin
                hb = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        a_in_flush = 1'b0;
        b_in_valid = 1'b0;
        b_in_flush = 1'b0;
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_product = '0; a_in_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_product = '0; b_in_flush = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_empty_flush();
        test_overflow();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
